dcache_line_mover: RTL and testbench
====================================

Name: dcache_line_mover

Overview:
- DRAM-side engine for the data-cache payload's line port: each port-B line is 256 bits with 32 per-byte dirty bits.
- Writeback: reads a line plus dirty bits over port B, streams it to memory as four 64-bit beats with byte strobes, then clears the dirty flags (op=0).
- Refill: fetches four beats from memory, assembles the line and writes it with op=1, so only clean bytes are loaded.
- Sits between the data-cache controller (start/done) and the memory bus.

Parameters:
- LINE_AW, 10, port-B line index width.
- MEM_AW, 32, memory byte-address width; line = 32 bytes, beat = 8 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_start  in  1  one-cycle pulse: write back line
- rf_start  in  1  one-cycle pulse: refill line
- line_idx  in  LINE_AW  port-B line index, sampled with a start pulse
- mem_line  in  MEM_AW-5  memory line address, sampled with a start pulse
- busy  out  1  engine not idle
- wb_done  out  1  one-cycle pulse, writeback complete
- rf_done  out  1  one-cycle pulse, refill complete
- addrb  out  LINE_AW  port-B address
- enb  out  1  port-B enable
- web  out  1  port-B write enable
- op  out  1  0 = clean write, 1 = refill write
- dinb  out  256  refill line
- doutb  in  256  line read data; byte j = bits [8j+7:8j]
- dirtyb  in  32  dirty bit per byte
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  write beat accepted
- mem_waddr  out  MEM_AW  beat address {line, beat[1:0], 3'b0}
- mem_wdata  out  64  line bits [64k+63:64k] for beat k
- mem_wstrb  out  8  dirtyb[8k+7:8k]
- mem_wlast  out  1  beat 3
- mem_arvalid  out  1  line read request
- mem_arready  in  1  request accepted
- mem_araddr  out  MEM_AW  {line, 5'b0}
- mem_rvalid  in  1  read beat valid (no back-pressure)
- mem_rdata  in  64  read beat, beats in order 0..3

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: busy, wb_done, rf_done, enb, web, op, mem_wvalid, mem_wlast, mem_arvalid. Beat counter 0, rf_pend 0. Reset mid-transfer aborts immediately; no port-B write is issued.
- States: IDLE, WB_RD, WB_CAP, WB_SEND, WB_CLR, RF_AR, RF_DATA, RF_WR.
- Start pulses are honoured only in IDLE; pulses while busy are ignored.
- wb_start and rf_start in the same IDLE cycle: writeback runs first and rf_pend is set. After WB_CLR the engine goes straight to RF_AR with the same line and address. wb_done pulses, and rf_done pulses later.
- busy = (state != IDLE); it rises the cycle after an accepted start.
- WB_RD: enb=1, web=0, addrb=line_idx. Next state WB_CAP.
- WB_CAP: latch doutb and dirtyb into the line buffer; counter=0. Next state WB_SEND.
- WB_SEND: mem_wvalid=1, driven from the buffer for beat = counter. Beat advances on wvalid&wready. wdata, strb and addr stay stable while wready is low. After beat 3 is accepted, next state WB_CLR.
- WB_CLR: enb=1, web=1, op=0, addrb=line. This relies on port B still presenting the WB_RD data. The FSM issues no other port-B access in between.
- After WB_CLR: wb_done=1 for one cycle, then IDLE, or RF_AR if rf_pend.
- RF_AR: mem_arvalid=1 until arready; araddr is stable meanwhile.
- RF_DATA: each rvalid writes mem_rdata into buffer beat=counter, counter+1. After the 4th beat, next state RF_WR. rvalid in any other state is ignored.
- RF_WR: enb=1, web=1, op=1, dinb=buffer. Next cycle rf_done=1, then IDLE.
- Minimum latency: writeback start to wb_done = 8 cycles with wready tied high; refill start to rf_done = 7 cycles with arready high and rvalid back-to-back.
- The controller must block port-A writes to the target line while busy. A dirty bit set mid-writeback would be cleared and lost.
- Beat counter is 2 bits; it wraps naturally and resets to 0 on entering WB_SEND or RF_DATA.

Optional Feature:
- Macro: DCACHE_WB_SKIP_CLEAN_EN.
- Defined:
  - In WB_SEND, beats whose strobe is 8'h00 are skipped without asserting mem_wvalid. mem_wlast marks the last non-zero-strobe beat.
  - If all 32 dirty bits are 0, WB_CAP goes directly to the done pulse: no memory traffic and no WB_CLR.
- Undefined: all four beats are always sent and WB_CLR always issued.

Test Plan:
- Writeback, line_idx=10'h05, mem_line=27'h10, dirtyb=32'h0000_00F0, wready=1 -> four beats at waddr 0x200/0x208/0x210/0x218; wstrb F0,00,00,00; wlast on 0x218; WB_CLR with op=0, addrb=5; wb_done at cycle 8.
- Writeback with wready low for 3 cycles on beat 1 -> wdata/waddr/wstrb held constant; beat order unchanged; wb_done delayed by 3.
- Refill line 7, arready delayed 2 cycles, rdata beats 64'h1111..,2222..,3333..,4444.. -> dinb = {4444..,3333..,2222..,1111..}; enb=web=op=1, addrb=7; rf_done 1 cycle after.
- Simultaneous wb_start and rf_start -> WB sequence, wb_done, then araddr issued the next cycle; rf_done after; a start pulse during busy is ignored.
- Assert rst_n low during RF_DATA after 2 beats -> outputs 0 asynchronously; no RF_WR; a fresh refill completes normally.
- With DCACHE_WB_SKIP_CLEAN_EN and dirtyb=0 -> no mem_wvalid, no WB_CLR, wb_done 3 cycles after start.

Source files
------------

// File: rtl/dcache_line_mover.sv
// Moves 256-bit lines between data-cache port B and a 64-bit memory bus (writeback, refill).
// DCACHE_WB_SKIP_CLEAN_EN skips clean beats/lines on writeback; writes stall on mem_wready, reads have no back-pressure.
module dcache_line_mover #(
  parameter int LINE_AW = 10,
  parameter int MEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_start,
  input  logic               rf_start,
  input  logic [LINE_AW-1:0] line_idx,
  input  logic [MEM_AW-6:0]  mem_line,
  output logic               busy,
  output logic               wb_done,
  output logic               rf_done,
  output logic [LINE_AW-1:0] addrb,
  output logic               enb,
  output logic               web,
  output logic               op,
  output logic [255:0]       dinb,
  input  logic [255:0]       doutb,
  input  logic [31:0]        dirtyb,
  output logic               mem_wvalid,
  input  logic               mem_wready,
  output logic [MEM_AW-1:0]  mem_waddr,
  output logic [63:0]        mem_wdata,
  output logic [7:0]         mem_wstrb,
  output logic               mem_wlast,
  output logic               mem_arvalid,
  input  logic               mem_arready,
  output logic [MEM_AW-1:0]  mem_araddr,
  input  logic               mem_rvalid,
  input  logic [63:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_CAP, WB_SEND, WB_CLR, RF_AR, RF_DATA, RF_WR
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         beat;
  logic [LINE_AW-1:0] idx_q;
  logic [MEM_AW-6:0]  line_q;
  logic [255:0]       line_buf;
  logic [31:0]        dirty_buf;
  logic               rf_pend;
  logic               wb_done_q, rf_done_q;
  logic [63:0]        beat_dat;
  logic [7:0]         beat_strb;
  logic [1:0]         last_beat;
  logic               beat_skip, skip_all, beat_adv, wb_fin;

  assign beat_dat  = line_buf[{beat, 6'd0} +: 64];
  assign beat_strb = dirty_buf[{beat, 3'd0} +: 8];

`ifdef DCACHE_WB_SKIP_CLEAN_EN
  // Highest beat carrying any dirty byte; that beat carries mem_wlast.
  always_comb begin
    last_beat = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (dirty_buf[8*k +: 8] != 8'h00) last_beat = 2'(k);
    end
  end
  assign skip_all  = (dirtyb == 32'h0);
  assign beat_skip = (beat_strb == 8'h00);
`else
  assign last_beat = 2'd3;
  assign skip_all  = 1'b0;
  assign beat_skip = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    enb         = 1'b0;
    web         = 1'b0;
    op          = 1'b0;
    mem_wvalid  = 1'b0;
    mem_wlast   = 1'b0;
    mem_arvalid = 1'b0;
    beat_adv    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_start)      state_nxt = WB_RD;
        else if (rf_start) state_nxt = RF_AR;
      end
      WB_RD: begin
        enb       = 1'b1;
        state_nxt = WB_CAP;
      end
      WB_CAP: begin
        if (skip_all) state_nxt = rf_pend ? RF_AR : IDLE;
        else          state_nxt = WB_SEND;
      end
      WB_SEND: begin
        mem_wvalid = !beat_skip;
        mem_wlast  = !beat_skip && (beat == last_beat);
        beat_adv   = beat_skip || mem_wready;
        if (beat_adv && (beat == last_beat)) state_nxt = WB_CLR;
      end
      // Port B still presents the WB_RD read, so op=0 clears exactly the bytes just sent.
      WB_CLR: begin
        enb       = 1'b1;
        web       = 1'b1;
        state_nxt = rf_pend ? RF_AR : IDLE;
      end
      RF_AR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) state_nxt = RF_DATA;
      end
      RF_DATA: begin
        if (mem_rvalid && (beat == 2'd3)) state_nxt = RF_WR;
      end
      RF_WR: begin
        enb       = 1'b1;
        web       = 1'b1;
        op        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_fin = (state == WB_CLR) || ((state == WB_CAP) && skip_all);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= 2'd0;
      idx_q     <= '0;
      line_q    <= '0;
      line_buf  <= '0;
      dirty_buf <= '0;
      rf_pend   <= 1'b0;
      wb_done_q <= 1'b0;
      rf_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wb_done_q <= wb_fin;
      rf_done_q <= (state == RF_WR);
      case (state)
        IDLE: begin
          if (wb_start || rf_start) begin
            idx_q   <= line_idx;
            line_q  <= mem_line;
            rf_pend <= wb_start && rf_start;
          end
        end
        WB_CAP: begin
          line_buf  <= doutb;
          dirty_buf <= dirtyb;
          beat      <= 2'd0;
        end
        WB_SEND: begin
          if (beat_adv) beat <= beat + 2'd1;
        end
        RF_AR: begin
          beat    <= 2'd0;
          rf_pend <= 1'b0;
        end
        RF_DATA: begin
          if (mem_rvalid) begin
            line_buf[{beat, 6'd0} +: 64] <= mem_rdata;
            beat                         <= beat + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign wb_done     = wb_done_q;
  assign rf_done     = rf_done_q;
  assign addrb       = idx_q;
  assign dinb        = line_buf;
  assign mem_waddr   = {line_q, beat, 3'b000};
  assign mem_wdata   = beat_dat;
  assign mem_wstrb   = beat_strb;
  assign mem_araddr  = {line_q, 5'b00000};

endmodule

// File: tb/tb_dcache_line_mover.sv
// Bench for dcache_line_mover: vector table of line transfers, scoreboard queues for memory beats and port-B writes.
module tb_dcache_line_mover;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_start, rf_start;
  logic [9:0]   line_idx;
  logic [26:0]  mem_line;
  logic         busy, wb_done, rf_done;
  logic [9:0]   addrb;
  logic         enb, web, op;
  logic [255:0] dinb, doutb;
  logic [31:0]  dirtyb;
  logic         mem_wvalid, mem_wready, mem_wlast;
  logic [31:0]  mem_waddr;
  logic [63:0]  mem_wdata;
  logic [7:0]   mem_wstrb;
  logic         mem_arvalid, mem_arready;
  logic [31:0]  mem_araddr;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;

  always #5 clk = ~clk;

  dcache_line_mover #(.LINE_AW(10), .MEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_start(wb_start), .rf_start(rf_start),
    .line_idx(line_idx), .mem_line(mem_line), .busy(busy), .wb_done(wb_done),
    .rf_done(rf_done), .addrb(addrb), .enb(enb), .web(web), .op(op), .dinb(dinb),
    .doutb(doutb), .dirtyb(dirtyb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wlast(mem_wlast), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(mem_araddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit           do_wb, do_rf;
    logic [9:0]   idx;
    logic [26:0]  mline;
    logic [31:0]  dirty;
    logic [255:0] line;
    int           stall_beat, stall_cyc, ar_dly, busy_pulse, exp_wb, exp_rf;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [63:0] dat; logic [7:0] strb; logic last; } wbeat_t;
  typedef struct { logic [9:0] addr; logic op; logic [255:0] din; } pbw_t;

  vec_t        vt[6];
  wbeat_t      wq[$];
  pbw_t        bq[$];
  int          n_vec = 0, n_err = 0, cur_vec = 0;
  int          cyc, wb_done_cyc, rf_done_cyc, wb_done_n, rf_done_n;
  int          wb_acc, stall_beat, stall_left, ar_left, r_beat;
  bit          r_active;
  logic [63:0] rbeats[4];
  logic [31:0] exp_araddr;
  logic [9:0]  exp_idx;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0h expected %0h", cur_vec, nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, bit r, logic [9:0] idx, logic [26:0] ml, logic [31:0] d,
                              int sb, int sc, int ad, int bp, int ew, int er);
    vec_t v;
    v.do_wb = w; v.do_rf = r; v.idx = idx; v.mline = ml; v.dirty = d;
    v.stall_beat = sb; v.stall_cyc = sc; v.ar_dly = ad; v.busy_pulse = bp;
    v.exp_wb = ew; v.exp_rf = er;
    for (int b = 0; b < 32; b++) v.line[8*b +: 8] = 8'(b * 13 + int'(idx) + 1);
    return v;
  endfunction

  // Memory-side responder, evaluated once outputs have settled after the clock edge.
  task automatic respond();
    mem_wready = 1'b1;
    if (mem_wvalid && wb_acc == stall_beat && stall_left > 0) begin
      mem_wready = 1'b0;
      stall_left--;
    end
    mem_arready = 1'b0;
    if (mem_arvalid) begin
      if (ar_left > 0) ar_left--;
      else mem_arready = 1'b1;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (r_active && r_beat < 4) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rbeats[r_beat];
    end
  endtask

  task automatic observe();
    if (mem_wvalid) begin
      chk("w_expected", wq.size() > 0, 1'b1);
      if (wq.size() > 0) begin
        chk("w_beat", {mem_waddr, mem_wdata, mem_wstrb, mem_wlast},
            {wq[0].addr, wq[0].dat, wq[0].strb, wq[0].last});
        if (mem_wready) begin
          void'(wq.pop_front());
          wb_acc++;
        end
      end
    end
    if (mem_arvalid) begin
      chk("araddr", mem_araddr, exp_araddr);
      if (mem_arready) begin r_active = 1'b1; r_beat = 0; end
    end
    if (mem_rvalid) begin
      r_beat++;
      if (r_beat == 4) r_active = 1'b0;
    end
    if (enb && !web) chk("rd_addr", addrb, exp_idx);
    if (enb && web) begin
      chk("b_expected", bq.size() > 0, 1'b1);
      if (bq.size() > 0) begin
        chk("b_addr_op", {addrb, op}, {bq[0].addr, bq[0].op});
        if (bq[0].op) chk("b_dinb", dinb, bq[0].din);
        void'(bq.pop_front());
      end
    end
    if (wb_done) begin wb_done_n++; if (wb_done_cyc < 0) wb_done_cyc = cyc; end
    if (rf_done) begin rf_done_n++; if (rf_done_cyc < 0) rf_done_cyc = cyc; end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    wb_start = 1'b0;
    rf_start = 1'b0;
    respond();
  endtask

  task automatic cycle_end();
    @(negedge clk);
    observe();
  endtask

  task automatic clear_state(input logic [9:0] idx, input logic [26:0] ml);
    wb_done_cyc = -1; rf_done_cyc = -1; wb_done_n = 0; rf_done_n = 0;
    wb_acc = 0; stall_beat = -1; stall_left = 0; ar_left = 0;
    r_active = 1'b0; r_beat = 0;
    exp_idx = idx; exp_araddr = {ml, 5'b00000};
    for (int k = 0; k < 4; k++) rbeats[k] = {16{4'(k + 1)}} ^ {54'd0, idx};
  endtask

  task automatic run_vec(input vec_t v);
    int last_k;
    clear_state(v.idx, v.mline);
    stall_beat = v.stall_beat; stall_left = v.stall_cyc; ar_left = v.ar_dly;
    if (v.do_wb) begin
      last_k = 3;
`ifdef DCACHE_WB_SKIP_CLEAN_EN
      last_k = -1;
      for (int k = 0; k < 4; k++) if (v.dirty[8*k +: 8] != 8'h00) last_k = k;
`endif
      for (int k = 0; k < 4; k++) begin
        if (k <= last_k) begin
`ifdef DCACHE_WB_SKIP_CLEAN_EN
          if (v.dirty[8*k +: 8] != 8'h00)
`endif
          wq.push_back('{addr: {v.mline, 2'(k), 3'b000}, dat: v.line[64*k +: 64],
                         strb: v.dirty[8*k +: 8], last: (k == last_k)});
        end
      end
      if (last_k >= 0) bq.push_back('{addr: v.idx, op: 1'b0, din: '0});
    end
    if (v.do_rf) bq.push_back('{addr: v.idx, op: 1'b1, din: {rbeats[3], rbeats[2], rbeats[1], rbeats[0]}});

    cycle_begin();
    wb_start = v.do_wb; rf_start = v.do_rf;
    line_idx = v.idx; mem_line = v.mline; doutb = v.line; dirtyb = v.dirty;
    cyc = 0;
    cycle_end();
    chk("busy_c0", busy, 1'b0);
    while (cyc < 100 && !((!v.do_wb || wb_done_cyc >= 0) && (!v.do_rf || rf_done_cyc >= 0))) begin
      cycle_begin();
      cyc++;
      if (cyc == 1) begin line_idx = ~v.idx; mem_line = ~v.mline; end
      if (cyc == 3) begin doutb = ~v.line; dirtyb = ~v.dirty; end
      if (cyc == v.busy_pulse) begin wb_start = 1'b1; rf_start = 1'b1; end
      cycle_end();
      if (cyc == 1) chk("busy_c1", busy, 1'b1);
    end
    repeat (4) begin cycle_begin(); cyc++; cycle_end(); end
    if (v.exp_wb != -2) chk("wb_latency", wb_done_cyc, v.exp_wb);
    if (v.exp_rf != -2) chk("rf_latency", rf_done_cyc, v.exp_rf);
    chk("wb_done_pulses", wb_done_n, v.do_wb ? 1 : 0);
    chk("rf_done_pulses", rf_done_n, v.do_rf ? 1 : 0);
    chk("queues_drained", wq.size() + bq.size(), 0);
    chk("idle_after", busy, 1'b0);
    wq.delete();
    bq.delete();
  endtask

  initial begin
    rst_n = 1'b0; wb_start = 1'b0; rf_start = 1'b0; line_idx = '0; mem_line = '0;
    doutb = '0; dirtyb = '0; mem_wready = 1'b0; mem_arready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    clear_state(10'd0, 27'd0);

    //          wb    rf    idx      mline          dirty          sb  sc ad  bp  exp_wb exp_rf
    vt[0] = mk(1'b1, 1'b0, 10'h005, 27'h0000010,  32'h0000_00F0, -1, 0, 0, -1,  8, -1);
    vt[1] = mk(1'b1, 1'b0, 10'h3FF, 27'h7FFFFFF,  32'h8001_FF3C,  1, 3, 0, -1, 11, -1);
    vt[2] = mk(1'b1, 1'b0, 10'h100, 27'h0000000,  32'h0000_0000, -1, 0, 0, -1,  8, -1);
    vt[3] = mk(1'b0, 1'b1, 10'h007, 27'h0001234,  32'h0000_0000, -1, 0, 2, -1, -1,  9);
    vt[4] = mk(1'b1, 1'b1, 10'h00A, 27'h00ABCDE,  32'hFFFF_FFFF, -1, 0, 0,  3,  8, 14);
    vt[5] = mk(1'b0, 1'b1, 10'h000, 27'h7FFFFFF,  32'h0000_0000, -1, 0, 0, -1, -1,  7);
`ifdef DCACHE_WB_SKIP_CLEAN_EN
    vt[0].exp_wb = -2;
    vt[2].exp_wb = 3;
`endif

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, wb_done, rf_done, enb, web, op, mem_wvalid, mem_wlast, mem_arvalid}, 9'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cur_vec = i;
      run_vec(vt[i]);
    end

    // Reset during RF_DATA after two beats: must abort with no port-B write.
    cur_vec = 90;
    clear_state(10'h02A, 27'h0000055);
    cycle_begin();
    rf_start = 1'b1; line_idx = 10'h02A; mem_line = 27'h0000055;
    cycle_end();
    for (int g = 0; g < 20 && r_beat < 2; g++) begin cycle_begin(); cycle_end(); end
    chk("rst_two_beats", r_beat, 2);
    @(posedge clk);
    #1;
    chk("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    mem_rvalid = 1'b0;
    r_active = 1'b0;
    #1;
    chk("rst_async_outputs", {busy, wb_done, rf_done, enb, web, op, mem_wvalid, mem_wlast, mem_arvalid}, 9'b0);
    repeat (2) begin cycle_begin(); cycle_end(); end
    rst_n = 1'b1;
    repeat (8) begin cycle_begin(); cycle_end(); end
    chk("rst_no_rf_done", rf_done_n, 0);
    chk("rst_idle", busy, 1'b0);

    cur_vec = 5;
    run_vec(vt[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
